// File: rtl/decoder_pkg.sv
// decoder_pkg: fault constants, BIST states and a one-hot helper shared by the decoder and its bench
package decoder_pkg;
   localparam int MAX_IN_W = 8;
   localparam logic FAULT_SA0 = 1'b0;
   localparam logic FAULT_SA1 = 1'b1;
   typedef enum logic [1:0] {IDLE, SWEEP, DRAIN, DONE} state_t;
   function automatic logic [2**MAX_IN_W-1:0] onehot(input logic [MAX_IN_W-1:0] code);
      return {{(2**MAX_IN_W-1){1'b0}}, 1'b1} << code;
   endfunction
endpackage

// File: rtl/decoder_fault_core.sv
// decoder_fault_core: applies the configured stuck-at fault to a code and one-hot encodes the result
module decoder_fault_core
   import decoder_pkg::*;
#(
   parameter int IN_W = 4,
   parameter int FB_W = 2,
   localparam int OUT_W = 2**IN_W
) (
   input  logic [IN_W-1:0]  code,
   input  logic             fault_en,
   input  logic [FB_W-1:0]  fault_bit,
   input  logic             fault_type,
   input  logic             fault_cond,
   output logic [OUT_W-1:0] onehot_out
);
   logic [IN_W-1:0] mask;
   logic [IN_W-1:0] code_f;
   logic            active;
   always_comb begin
      mask = IN_W'(1) << fault_bit;
      // the MSB condition looks at the unfaulted code, even when the MSB itself is the faulted bit
      active = fault_en & (32'(fault_bit) < IN_W) & (~fault_cond | code[IN_W-1]);
      code_f = !active ? code : (fault_type == FAULT_SA1) ? (code | mask) : (code & ~mask);
      onehot_out = OUT_W'(onehot(MAX_IN_W'(code_f)));
   end
endmodule

// File: rtl/decoder_nx_fault_bist.sv
// decoder_nx_fault_bist: registered one-hot decoder with stuck-at fault injection and a self-test sweep
module decoder_nx_fault_bist
   import decoder_pkg::*;
#(
   parameter int IN_W = 4,
   parameter int FB_W = 2,
   localparam int OUT_W = 2**IN_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [IN_W-1:0]  d_in,
   input  logic             d_valid,
   output logic [OUT_W-1:0] d_out,
   output logic             d_out_valid,
   input  logic             fault_en,
   input  logic [FB_W-1:0]  fault_bit,
   input  logic             fault_type,
   input  logic             fault_cond,
   input  logic             bist_start,
   output logic             bist_busy,
   output logic             bist_done,
   output logic             bist_pass,
   output logic [IN_W:0]    bist_err_cnt,
   output logic [IN_W-1:0]  bist_first_fail
);
   state_t           state_q, state_d;
   logic [IN_W-1:0]  cnt_q, cnt_d, code_q, code_d, first_fail_q, first_fail_d;
   logic [OUT_W-1:0] d_out_q, d_out_d, core_out;
   logic             d_out_valid_q, d_out_valid_d, cmp_q, cmp_d;
   logic             sh_en_q, sh_en_d, sh_type_q, sh_type_d, sh_cond_q, sh_cond_d;
   logic [FB_W-1:0]  sh_bit_q, sh_bit_d;
   logic [IN_W:0]    err_cnt_q, err_cnt_d;
   logic             pass_q, pass_d, done_q, done_d;
   logic             sweep, mismatch;
   assign sweep = (state_q == SWEEP);
   decoder_fault_core #(.IN_W(IN_W), .FB_W(FB_W)) u_core (
      .code       (sweep ? cnt_q : d_in),
      .fault_en   (sweep ? sh_en_q : fault_en),
      .fault_bit  (sweep ? sh_bit_q : fault_bit),
      .fault_type (sweep ? sh_type_q : fault_type),
      .fault_cond (sweep ? sh_cond_q : fault_cond),
      .onehot_out (core_out)
   );
   always_comb begin
      state_d = state_q;
      cnt_d = cnt_q;
      sh_en_d = sh_en_q;
      sh_bit_d = sh_bit_q;
      sh_type_d = sh_type_q;
      sh_cond_d = sh_cond_q;
      err_cnt_d = err_cnt_q;
      first_fail_d = first_fail_q;
      pass_d = pass_q;
      done_d = 1'b0;
      code_d = sweep ? cnt_q : d_in;
      d_out_d = core_out;
      d_out_valid_d = d_valid & (state_q == IDLE || state_q == DONE);
      // cmp_q marks that d_out_q holds a sweep code, giving one compare per code
      cmp_d = sweep;
      mismatch = cmp_q & (d_out_q != OUT_W'(onehot(MAX_IN_W'(code_q))));
      if (mismatch) begin
         err_cnt_d = err_cnt_q + 1'b1;
         first_fail_d = (err_cnt_q == '0) ? code_q : first_fail_q;
      end
      case (state_q)
         IDLE: if (bist_start) begin
            state_d = SWEEP;
            sh_en_d = fault_en;
            sh_bit_d = fault_bit;
            sh_type_d = fault_type;
            sh_cond_d = fault_cond;
            err_cnt_d = '0;
            first_fail_d = '0;
            pass_d = 1'b0;
            cnt_d = '0;
         end
         SWEEP: begin
            cnt_d = cnt_q + 1'b1;
            state_d = (cnt_q == '1) ? DRAIN : SWEEP;
         end
         DRAIN: state_d = DONE;
         default: begin
            state_d = IDLE;
            done_d = 1'b1;
            pass_d = (err_cnt_q == '0);
         end
      endcase
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q <= '0;
         code_q <= '0;
         d_out_q <= '0;
         d_out_valid_q <= 1'b0;
         cmp_q <= 1'b0;
         sh_en_q <= 1'b0;
         sh_bit_q <= '0;
         sh_type_q <= 1'b0;
         sh_cond_q <= 1'b0;
         err_cnt_q <= '0;
         first_fail_q <= '0;
         pass_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q <= cnt_d;
         code_q <= code_d;
         d_out_q <= d_out_d;
         d_out_valid_q <= d_out_valid_d;
         cmp_q <= cmp_d;
         sh_en_q <= sh_en_d;
         sh_bit_q <= sh_bit_d;
         sh_type_q <= sh_type_d;
         sh_cond_q <= sh_cond_d;
         err_cnt_q <= err_cnt_d;
         first_fail_q <= first_fail_d;
         pass_q <= pass_d;
         done_q <= done_d;
      end
   end
   assign d_out = d_out_q;
   assign d_out_valid = d_out_valid_q;
   assign bist_busy = (state_q == SWEEP) || (state_q == DRAIN);
   assign bist_done = done_q;
   assign bist_pass = pass_q;
   assign bist_err_cnt = err_cnt_q;
   assign bist_first_fail = first_fail_q;
endmodule

// File: tb/tb_decoder_nx_fault_bist.sv
// tb_decoder_nx_fault_bist: vector table, directed BIST sequences and random checks against a behavioural model
module tb_decoder_nx_fault_bist;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [3:0]  d_in = '0;
   logic        d_valid = 1'b0;
   logic [15:0] d_out;
   logic        d_out_valid;
   logic        fault_en = 1'b0;
   logic [1:0]  fault_bit = '0;
   logic        fault_type = 1'b0;
   logic        fault_cond = 1'b0;
   logic        bist_start = 1'b0;
   logic        bist_busy, bist_done, bist_pass;
   logic [4:0]  bist_err_cnt;
   logic [3:0]  bist_first_fail;
   logic [2:0]  b_din = '0;
   logic        b_dv = 1'b0;
   logic [7:0]  b_dout;
   logic        b_dov;
   logic        b_fe = 1'b0;
   logic [2:0]  b_fb = '0;
   logic        b_ft = 1'b0;
   logic        b_fc = 1'b0;
   logic        b_start = 1'b0;
   logic        b_busy, b_done, b_pass;
   logic [3:0]  b_err;
   logic [2:0]  b_ff;
   int          n_pass = 0;
   int          n_total = 0;

   decoder_nx_fault_bist #(.IN_W(4), .FB_W(2)) dut (
      .clk(clk), .rst_n(rst_n), .d_in(d_in), .d_valid(d_valid), .d_out(d_out),
      .d_out_valid(d_out_valid), .fault_en(fault_en), .fault_bit(fault_bit),
      .fault_type(fault_type), .fault_cond(fault_cond), .bist_start(bist_start),
      .bist_busy(bist_busy), .bist_done(bist_done), .bist_pass(bist_pass),
      .bist_err_cnt(bist_err_cnt), .bist_first_fail(bist_first_fail)
   );

   decoder_nx_fault_bist #(.IN_W(3), .FB_W(3)) dut_b (
      .clk(clk), .rst_n(rst_n), .d_in(b_din), .d_valid(b_dv), .d_out(b_dout),
      .d_out_valid(b_dov), .fault_en(b_fe), .fault_bit(b_fb),
      .fault_type(b_ft), .fault_cond(b_fc), .bist_start(b_start),
      .bist_busy(b_busy), .bist_done(b_done), .bist_pass(b_pass),
      .bist_err_cnt(b_err), .bist_first_fail(b_ff)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   // code after fault, derived directly from the fault rules
   function automatic int ref_code(int code, int w, int en, int b, int ft, int fc);
      int msb = (code >> (w - 1)) & 1;
      if (en == 0 || b >= w || (fc != 0 && msb == 0)) return code;
      return (ft != 0) ? (code | (1 << b)) : (code & ~(1 << b));
   endfunction

   task automatic model_bist(input int w, input int en, input int b, input int ft, input int fc,
                             output int err, output int ff);
      err = 0;
      ff = 0;
      for (int c = 0; c < (1 << w); c++)
         if (ref_code(c, w, en, b, ft, fc) != c) begin
            if (err == 0) ff = c;
            err++;
         end
   endtask

   task automatic run_bist(input string nm, input int exp_err, input int exp_ff, input bit disturb);
      int k;
      bist_start = 1'b1;
      tick();
      bist_start = 1'b0;
      chk({nm, "_busy"}, bist_busy, 1);
      k = 0;
      while (!bist_done && k < 100) begin
         if (disturb && k == 4) begin
            bist_start = 1'b1;
            fault_type = ~fault_type;
         end
         if (disturb && k == 5) bist_start = 1'b0;
         tick();
         k++;
      end
      chk({nm, "_edges"}, k, 18);
      chk({nm, "_pass"}, bist_pass, (exp_err == 0));
      chk({nm, "_err"}, bist_err_cnt, exp_err);
      chk({nm, "_ff"}, bist_first_fail, exp_ff);
      chk({nm, "_busy_end"}, bist_busy, 0);
      tick();
      chk({nm, "_done_pulse"}, bist_done, 0);
      chk({nm, "_err_hold"}, bist_err_cnt, exp_err);
   endtask

   typedef struct {
      logic [3:0]  din;
      logic        dv, fe;
      logic [1:0]  fb;
      logic        ft, fc;
      logic [15:0] exp_out;
      logic        exp_v;
   } vec_t;

   vec_t vecs[6];

   initial begin
      int e, f, k;
      vecs[0] = '{4'h5, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 16'h0020, 1'b1};
      vecs[1] = '{4'hE, 1'b1, 1'b1, 2'd2, 1'b0, 1'b1, 16'h0400, 1'b1};
      vecs[2] = '{4'h6, 1'b1, 1'b1, 2'd2, 1'b0, 1'b1, 16'h0040, 1'b1};
      vecs[3] = '{4'h3, 1'b0, 1'b1, 2'd2, 1'b0, 1'b1, 16'h0008, 1'b0};
      vecs[4] = '{4'h3, 1'b1, 1'b1, 2'd1, 1'b1, 1'b0, 16'h0008, 1'b1};
      vecs[5] = '{4'hF, 1'b1, 1'b1, 2'd3, 1'b0, 1'b1, 16'h0080, 1'b1};

      tick();
      tick();
      chk("rst_dout", d_out, 0);
      chk("rst_valid", d_out_valid, 0);
      chk("rst_busy", bist_busy, 0);
      chk("rst_done", bist_done, 0);
      chk("rst_pass", bist_pass, 0);
      chk("rst_err", bist_err_cnt, 0);
      chk("rst_ff", bist_first_fail, 0);
      rst_n = 1'b1;

      for (int i = 0; i < 6; i++) begin
         d_in = vecs[i].din;
         d_valid = vecs[i].dv;
         fault_en = vecs[i].fe;
         fault_bit = vecs[i].fb;
         fault_type = vecs[i].ft;
         fault_cond = vecs[i].fc;
         tick();
         chk($sformatf("vec%0d_out", i), d_out, vecs[i].exp_out);
         chk($sformatf("vec%0d_valid", i), d_out_valid, vecs[i].exp_v);
      end

      fault_en = 1'b1; fault_bit = 2'd2; fault_type = 1'b0; fault_cond = 1'b1;
      run_bist("bist_b2sa0c", 4, 12, 1'b0);
      run_bist("bist_disturb", 4, 12, 1'b1);
      fault_type = 1'b0;
      fault_bit = 2'd0; fault_type = 1'b1; fault_cond = 1'b0;
      run_bist("bist_b0sa1", 8, 0, 1'b0);
      fault_en = 1'b0;
      run_bist("bist_nofault", 0, 0, 1'b0);

      fault_en = 1'b1;
      bist_start = 1'b1;
      tick();
      bist_start = 1'b0;
      repeat (6) tick();
      rst_n = 1'b0;
      tick();
      chk("midrst_busy", bist_busy, 0);
      chk("midrst_err", bist_err_cnt, 0);
      chk("midrst_done", bist_done, 0);
      rst_n = 1'b1;
      run_bist("bist_after_rst", 8, 0, 1'b0);

      for (int r = 0; r < 3; r++) begin
         fault_en = 1'b1;
         fault_bit = 2'($urandom_range(0, 3));
         fault_type = 1'($urandom_range(0, 1));
         fault_cond = 1'($urandom_range(0, 1));
         model_bist(4, 1, int'(fault_bit), int'(fault_type), int'(fault_cond), e, f);
         run_bist($sformatf("bist_rnd%0d", r), e, f, 1'b0);
      end

      b_fe = 1'b1; b_fb = 3'd3; b_ft = 1'b1; b_fc = 1'b0;
      b_start = 1'b1;
      tick();
      b_start = 1'b0;
      k = 0;
      while (!b_done && k < 100) begin
         tick();
         k++;
      end
      chk("b_edges", k, 10);
      chk("b_pass", b_pass, 1);
      chk("b_err", b_err, 0);

      for (int r = 0; r < 60; r++) begin
         d_in = 4'($urandom); d_valid = 1'($urandom);
         fault_en = 1'($urandom); fault_bit = 2'($urandom);
         fault_type = 1'($urandom); fault_cond = 1'($urandom);
         b_din = 3'($urandom); b_dv = 1'($urandom);
         b_fe = 1'($urandom); b_fb = 3'($urandom);
         b_ft = 1'($urandom); b_fc = 1'($urandom);
         tick();
         chk("rnd_a_out", d_out, 32'd1 << ref_code(int'(d_in), 4, int'(fault_en), int'(fault_bit),
                                                   int'(fault_type), int'(fault_cond)));
         chk("rnd_a_valid", d_out_valid, d_valid);
         chk("rnd_b_out", b_dout, 32'd1 << ref_code(int'(b_din), 3, int'(b_fe), int'(b_fb),
                                                    int'(b_ft), int'(b_fc)));
         chk("rnd_b_valid", b_dov, b_dv);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
